// File: rtl/raycast_pkg.sv
// Shared raycasting types: scheduler state encoding, screen geometry and the
// player pose bundle that the controller, scheduler and ray stage pass around.
package raycast_pkg;

  localparam int SCREEN_COLS = 320;
  localparam int POSE_W      = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LATCH     = 3'd1,
    ISSUE     = 3'd2,
    DRAIN     = 3'd3,
    SWAP_WAIT = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [POSE_W-1:0] posX;
    logic [POSE_W-1:0] posY;
    logic [POSE_W-1:0] dirX;
    logic [POSE_W-1:0] dirY;
    logic [POSE_W-1:0] planeX;
    logic [POSE_W-1:0] planeY;
  } pose_t;

endpackage

// File: rtl/pose_snapshot_reg.sv
// Frame-stable copy of the player pose: loads on load_i, clears on rst_i.
module pose_snapshot_reg
  import raycast_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  pose_t pose_i,
  output pose_t pose_o
);

  pose_t pose_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pose_q <= '0;
    end else if (load_i) begin
      pose_q <= pose_i;
    end
  end

  assign pose_o = pose_q;

endmodule

// File: rtl/ray_frame_scheduler.sv
// Per-frame sequencer: snapshots the pose, issues one request per screen column,
// waits for the last pixel, then swaps the frame buffer on the next frame boundary.
module ray_frame_scheduler
  import raycast_pkg::*;
#(
  parameter int NUM_COLS      = SCREEN_COLS,
  parameter int HCOUNT_W      = 9,
  parameter int POSE_W        = raycast_pkg::POSE_W,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic                frame_start_in,
  input  logic [POSE_W-1:0]   posX_in,
  input  logic [POSE_W-1:0]   posY_in,
  input  logic [POSE_W-1:0]   dirX_in,
  input  logic [POSE_W-1:0]   dirY_in,
  input  logic [POSE_W-1:0]   planeX_in,
  input  logic [POSE_W-1:0]   planeY_in,
  input  logic                ray_ready_in,
  output logic                ray_valid_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [POSE_W-1:0]   posX_out,
  output logic [POSE_W-1:0]   posY_out,
  output logic [POSE_W-1:0]   dirX_out,
  output logic [POSE_W-1:0]   dirY_out,
  output logic [POSE_W-1:0]   planeX_out,
  output logic [POSE_W-1:0]   planeY_out,
  input  logic                frame_done_in,
  output logic                swap_out,
  output logic                busy_out,
  output logic [7:0]          frames_dropped_out,
  output logic                error_out,
  output logic [2:0]          state_out
);

  localparam int                  DRAIN_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [HCOUNT_W-1:0] LAST_COL   = HCOUNT_W'(NUM_COLS - 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  // Column channel: a request transfers on any edge where ray_valid_out and
  // ray_ready_in are both high; until then valid and hcount are held unchanged.

  sched_state_t        state_q, state_d;
  logic [HCOUNT_W-1:0] hcount_q, hcount_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [7:0]          dropped_q, dropped_d;
  logic                error_q, error_d;
  logic                swap_q, swap_d;
  pose_t               pose_live, pose_snap;

  always_comb begin
    state_d   = state_q;
    hcount_d  = hcount_q;
    drain_d   = drain_q;
    dropped_d = dropped_q;
    error_d   = error_q;
    swap_d    = 1'b0;

    if (frame_done_in && (state_q != DRAIN)) begin
      error_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_start_in && enable_in) state_d = LATCH;
      end
      LATCH: begin
        hcount_d = '0;
        state_d  = ISSUE;
      end
      ISSUE: begin
        if (ray_ready_in) begin
          if (hcount_q == LAST_COL) begin
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            hcount_d = hcount_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        // A done pulse on the timeout cycle still counts as a clean finish.
        if (frame_done_in) begin
          state_d = SWAP_WAIT;
        end else if (drain_q == DRAIN_LAST) begin
          error_d = 1'b1;
          state_d = SWAP_WAIT;
        end
      end
      SWAP_WAIT: begin
        if (frame_start_in) begin
          swap_d  = 1'b1;
          state_d = enable_in ? LATCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_start_in && (state_q inside {LATCH, ISSUE, DRAIN}) &&
        (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      hcount_q  <= '0;
      drain_q   <= '0;
      dropped_q <= '0;
      error_q   <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcount_q  <= hcount_d;
      drain_q   <= drain_d;
      dropped_q <= dropped_d;
      error_q   <= error_d;
      swap_q    <= swap_d;
    end
  end

  assign pose_live = '{posX: posX_in, posY: posY_in, dirX: dirX_in,
                       dirY: dirY_in, planeX: planeX_in, planeY: planeY_in};

  pose_snapshot_reg u_pose_snapshot (
    .clk_i  (pixel_clk_in),
    .rst_i  (rst_in),
    .load_i (state_q == LATCH),
    .pose_i (pose_live),
    .pose_o (pose_snap)
  );

  assign posX_out   = pose_snap.posX;
  assign posY_out   = pose_snap.posY;
  assign dirX_out   = pose_snap.dirX;
  assign dirY_out   = pose_snap.dirY;
  assign planeX_out = pose_snap.planeX;
  assign planeY_out = pose_snap.planeY;

  assign ray_valid_out      = (state_q == ISSUE);
  assign hcount_out         = hcount_q;
  assign swap_out           = swap_q;
  assign busy_out           = (state_q != IDLE);
  assign frames_dropped_out = dropped_q;
  assign error_out          = error_q;
  assign state_out          = state_q;

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Randomised bench for ray_frame_scheduler: column requests are predicted per
// frame into a scoreboard queue and matched by an independent monitor.
`timescale 1ns/1ps
module tb_ray_frame_scheduler;
  import raycast_pkg::*;

  localparam int NUM_COLS      = 4;
  localparam int HCOUNT_W      = 9;
  localparam int DRAIN_TIMEOUT = 20;
  localparam int EW            = HCOUNT_W + 96;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, enable, frame_start, frame_done;
  logic                ray_ready = 1'b0;
  logic [95:0]         pose_in;
  logic                ray_valid_o, swap_o, busy_o, error_o;
  logic [HCOUNT_W-1:0] hcount_o;
  logic [15:0]         posX_o, posY_o, dirX_o, dirY_o, planeX_o, planeY_o;
  logic [7:0]          drops_o;
  logic [2:0]          state_o;
  logic [95:0]         act_pose;

  assign act_pose = {posX_o, posY_o, dirX_o, dirY_o, planeX_o, planeY_o};

  ray_frame_scheduler #(
    .NUM_COLS(NUM_COLS), .HCOUNT_W(HCOUNT_W), .POSE_W(16), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .pixel_clk_in       (clk),
    .rst_in             (rst),
    .enable_in          (enable),
    .frame_start_in     (frame_start),
    .posX_in            (pose_in[95:80]),
    .posY_in            (pose_in[79:64]),
    .dirX_in            (pose_in[63:48]),
    .dirY_in            (pose_in[47:32]),
    .planeX_in          (pose_in[31:16]),
    .planeY_in          (pose_in[15:0]),
    .ray_ready_in       (ray_ready),
    .ray_valid_out      (ray_valid_o),
    .hcount_out         (hcount_o),
    .posX_out           (posX_o),
    .posY_out           (posY_o),
    .dirX_out           (dirX_o),
    .dirY_out           (dirY_o),
    .planeX_out         (planeX_o),
    .planeY_out         (planeY_o),
    .frame_done_in      (frame_done),
    .swap_out           (swap_o),
    .busy_out           (busy_o),
    .frames_dropped_out (drops_o),
    .error_out          (error_o),
    .state_out          (state_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int exp_drops = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- downstream ready driver ----------------
  int ready_mode = 0;  // 0 always, 1 random, 2 stalled, 3 pattern 1,0,0
  int tog = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: ray_ready = 1'b1;
      1: ray_ready = ($urandom_range(0, 99) < 55);
      2: ray_ready = 1'b0;
      default: begin
        ray_ready = (tog == 0);
        tog = (tog + 1) % 3;
      end
    endcase
  end

  // ---------------- monitor ----------------
  logic                stall_prev = 1'b0;
  logic [HCOUNT_W-1:0] hc_prev;
  logic [EW-1:0]       mon_e;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", ray_valid_o, 1);
        check("hold_hcount", hcount_o, hc_prev);
      end
      if (ray_valid_o && ray_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_column", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("col_hcount", hcount_o, mon_e[EW-1:96]);
          check("col_pose", act_pose, mon_e[95:0]);
        end
      end
      stall_prev = ray_valid_o && !ray_ready;
      hc_prev    = hcount_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] rand_pose();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Call at posedge+1 with the DUT in IDLE (enabled) or SWAP_WAIT.
  task automatic start_frame(input logic [95:0] p, input bit from_swap);
    pose_in     = p;
    frame_start = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) exp_q.push_back({HCOUNT_W'(c), p});
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("latch_state", state_o, LATCH);
    check("latch_busy", busy_o, 1);
    check("latch_valid", ray_valid_o, 0);
    check("swap_with_latch", swap_o, from_swap);
    tick();
    pose_in = rand_pose();
    @(negedge clk);
    check("issue_valid", ray_valid_o, 1);
    check("issue_first_hcount", hcount_o, 0);
    check("issue_busy", busy_o, 1);
    check("swap_one_cycle", swap_o, 0);
  endtask

  // Returns at the negedge of the first DRAIN cycle.
  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check("columns_in_budget", exp_q.size(), 0);
    @(negedge clk);
    check("drain_state", state_o, DRAIN);
    check("drain_valid_low", ray_valid_o, 0);
    check("drain_last_hcount", hcount_o, NUM_COLS - 1);
    check("drain_busy", busy_o, 1);
  endtask

  task automatic pulse_done();
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    @(negedge clk);
    check("after_done_state", state_o, SWAP_WAIT);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_drops = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [95:0] p;
    int cnt;
    rst = 1'b1; enable = 1'b0; frame_start = 1'b0; frame_done = 1'b0;
    pose_in = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", ray_valid_o, 0);
    check("rst_hcount", hcount_o, 0);
    check("rst_pose", act_pose, 0);
    check("rst_swap", swap_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_drops", drops_o, 0);
    check("rst_error", error_o, 0);
    check("rst_state", state_o, IDLE);
    tick();
    rst = 1'b0;

    // Frame boundary while disabled: ignored, not a drop.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("disabled_idle", state_o, IDLE);
    check("disabled_no_drop", drops_o, exp_drops);

    // Frame 1: full-rate downstream, posX 0x0100 then live pose moves to 0x0200.
    enable = 1'b1;
    tick();
    p = rand_pose();
    p[95:80] = 16'h0100;
    start_frame(p, 1'b0);
    pose_in[95:80] = 16'h0200;
    wait_drain();
    pulse_done();
    check("snapshot_held", posX_o, 16'h0100);
    repeat (50) tick();
    check("no_early_swap", swap_o, 0);
    check("swap_wait_holds", state_o, SWAP_WAIT);

    // Frame 2: ready pattern 1,0,0; drop a frame boundary during DRAIN.
    ready_mode = 3;
    p = rand_pose();
    p[95:80] = 16'h0200;
    start_frame(p, 1'b1);
    wait_drain();
    check("snapshot_new", posX_o, 16'h0200);
    tick();
    frame_start = 1'b1;
    exp_drops++;
    tick();
    frame_start = 1'b0;
    pulse_done();
    check("drop_in_drain", drops_o, exp_drops);
    check("done_no_error", error_o, 0);

    // Frame 3: stalled downstream, frame boundaries while issuing.
    ready_mode = 2;
    tick();
    start_frame(rand_pose(), 1'b1);
    tick();
    frame_start = 1'b1;
    repeat (3) tick();
    frame_start = 1'b0;
    exp_drops += 3;
    @(negedge clk);
    check("drops_three", drops_o, exp_drops);
    tick();
    frame_start = 1'b1;
    repeat (300) tick();
    frame_start = 1'b0;
    exp_drops = (exp_drops + 300 > 255) ? 255 : exp_drops + 300;
    @(negedge clk);
    check("drops_saturate", drops_o, exp_drops);
    check("stall_still_issue", state_o, ISSUE);
    ready_mode = 1;
    wait_drain();
    pulse_done();

    // Frame 4: enable dropped mid-frame; frame completes, swaps, then idles.
    tick();
    start_frame(rand_pose(), 1'b1);
    tick();
    enable = 1'b0;
    wait_drain();
    pulse_done();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("final_swap", swap_o, 1);
    check("final_idle", state_o, IDLE);
    check("final_not_busy", busy_o, 0);
    repeat (5) tick();
    check("stays_idle", state_o, IDLE);

    // Frame 5: no frame_done -> timeout after DRAIN_TIMEOUT cycles.
    enable = 1'b1;
    tick();
    start_frame(rand_pose(), 1'b0);
    wait_drain();
    cnt = 1;
    while (cnt < 100) begin
      @(negedge clk);
      if (state_o != DRAIN) break;
      cnt++;
    end
    check("timeout_cycles", cnt, DRAIN_TIMEOUT);
    check("timeout_state", state_o, SWAP_WAIT);
    check("timeout_error", error_o, 1);

    // frame_done outside DRAIN is an error.
    do_reset();
    @(negedge clk);
    check("reset_clears_error", error_o, 0);
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    @(negedge clk);
    check("stray_done_error", error_o, 1);
    check("stray_done_idle", state_o, IDLE);

    // frame_done on the timeout cycle wins.
    do_reset();
    ready_mode = 0;
    start_frame(rand_pose(), 1'b0);
    wait_drain();
    repeat (DRAIN_TIMEOUT - 1) tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    @(negedge clk);
    check("tie_state", state_o, SWAP_WAIT);
    check("tie_no_error", error_o, 0);

    // Reset mid-ISSUE restores every output.
    do_reset();
    ready_mode = 2;
    tick();
    start_frame(rand_pose(), 1'b0);
    tick();
    frame_start = 1'b1;
    frame_done  = 1'b1;
    tick();
    frame_start = 1'b0;
    frame_done  = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_valid", ray_valid_o, 0);
    check("midrst_hcount", hcount_o, 0);
    check("midrst_pose", act_pose, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_drops", drops_o, 0);
    check("midrst_error", error_o, 0);
    check("midrst_state", state_o, IDLE);
    exp_q.delete();
    tick();
    rst = 1'b0;
    ready_mode = 0;
    repeat (3) tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ray_frame_scheduler.md
Name: ray_frame_scheduler

Overview:
- Sequences the raycasting datapath once per video frame.
- Snapshots the player pose from the controller at a frame boundary, then issues exactly NUM_COLS column requests (hcount 0..NUM_COLS-1) to ray_calculations over a valid/ready handshake.
- Waits for the transformation stage to report the frame's last pixel written, then pulses a buffer swap to frame_buffer on the next video frame boundary.
- Counts overruns and flags pipeline stalls.

Parameters:
- NUM_COLS, 320, columns (rays) per frame; hcount_out runs 0..NUM_COLS-1.
- HCOUNT_W, 9, width of hcount_out; must satisfy 2^HCOUNT_W >= NUM_COLS.
- POSE_W, 16, width of each pose component.
- DRAIN_TIMEOUT, 65535, maximum cycles spent in DRAIN before an error is flagged.

Ports:
- pixel_clk_in  in  1  system pixel clock.
- rst_in  in  1  synchronous active-high reset.
- enable_in  in  1  level; 1 = render continuously, 0 = finish the current frame, then idle.
- frame_start_in  in  1  one-cycle pulse at the video frame boundary (video_sig_gen last pixel).
- posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in  in  POSE_W each  live pose from the controller.
- ray_ready_in  in  1  downstream ray_calculations / DDA-in FIFO can accept a column.
- ray_valid_out  out  1  column request valid.
- hcount_out  out  HCOUNT_W  column index of the current request.
- posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out  out  POSE_W each  frame-stable pose snapshot.
- frame_done_in  in  1  pulse from transformation (ray_last_pixel_out): the last column is written.
- swap_out  out  1  one-cycle pulse telling frame_buffer to swap buffers.
- busy_out  out  1  high in LATCH, ISSUE, DRAIN and SWAP_WAIT.
- frames_dropped_out  out  8  saturating count of frame_start_in pulses missed while rendering.
- error_out  out  1  sticky error flag; cleared only by rst_in.

Behaviour:
- Reset values (rst_in sampled high at an edge): state IDLE; ray_valid_out=0; hcount_out=0; every pose output=0; swap_out=0; busy_out=0; frames_dropped_out=0; error_out=0; drain counter=0.
- Reset has priority over all other inputs, including mid-frame.
- The block does not flush in-flight columns; downstream stages share rst_in.

State machine:
- IDLE: leave for LATCH when frame_start_in && enable_in.
- LATCH (1 cycle): register all six pose inputs into the *_out registers; set hcount_out=0; go to ISSUE.
- ISSUE:
  - ray_valid_out=1.
  - On ray_valid_out && ray_ready_in: if hcount_out==NUM_COLS-1, drop ray_valid_out and go to DRAIN; otherwise hcount_out+=1.
  - hcount_out never reaches NUM_COLS.
  - While ray_ready_in=0, ray_valid_out and hcount_out hold stable. Never retract valid before the handshake.
- DRAIN:
  - Wait for frame_done_in, then go to SWAP_WAIT.
  - Drain counter increments each cycle. If it reaches DRAIN_TIMEOUT: set error_out and go to SWAP_WAIT.
  - The drain counter clears on entry to DRAIN.
- SWAP_WAIT: on frame_start_in, assert swap_out for exactly that next cycle.
  - If enable_in=1, go to LATCH in the same transition (swap_out high concurrently with LATCH).
  - If enable_in=0, go to IDLE.

Latency and snapshot:
- frame_start_in high at edge N in IDLE: LATCH during cycle N+1; ray_valid_out=1 with hcount_out=0 from cycle N+2.
- Pose outputs change only in LATCH; they are constant through ISSUE, DRAIN and SWAP_WAIT.

Boundary conditions:
- frame_start_in in LATCH, ISSUE or DRAIN: frames_dropped_out += 1, saturating at 255. The pulse is otherwise ignored.
- frame_done_in outside DRAIN: set error_out, otherwise ignored.
- frame_done_in and timeout in the same cycle: frame_done_in wins, no error.
- enable_in dropped mid-frame: the current frame still completes, including the swap.
- Width: hcount_out is compared against NUM_COLS-1 at HCOUNT_W bits. Pose values pass through unmodified; no arithmetic is applied to them.

Decomposition:
- Shared package raycast_pkg holds:
  - state enum sched_state_t {IDLE, LATCH, ISSUE, DRAIN, SWAP_WAIT};
  - SCREEN_COLS=320;
  - POSE_W=16;
  - a packed struct pose_t {posX, posY, dirX, dirY, planeX, planeY}, reused by the controller and ray_calculations.
- One natural sub-module: pose_snapshot_reg. It is the pose_t register with a load enable and synchronous reset, so the snapshot can be reused by later multi-player or replay features.
- The FSM, column counter, drain counter and drop counter stay in the top of this block.

Test Plan:
1. NUM_COLS=4, ray_ready_in=1, enable_in=1, pulse frame_start_in at edge 10 -> ray_valid_out high cycles 12..15, hcount_out 0,1,2,3, then low, busy_out=1; pose_out equals inputs sampled at cycle 11.
2. NUM_COLS=4, ray_ready_in toggling 1,0,0,1,... -> exactly 4 handshakes with hcount_out 0..3 in order; hcount_out/valid stable during every ready=0 cycle; never hcount_out=4.
3. Change posX_in from 0x0100 to 0x0200 during ISSUE -> posX_out stays 0x0100 until the next LATCH, then reads 0x0200.
4. frame_done_in in DRAIN, then frame_start_in 50 cycles later -> swap_out high exactly one cycle after that pulse, new LATCH in the same cycle, hcount_out restarts at 0.
5. Three frame_start_in pulses during ISSUE (ray_ready_in=0) -> frames_dropped_out=3; 300 pulses -> saturates at 255.
6. DRAIN_TIMEOUT=20, never pulse frame_done_in -> error_out=1 after 20 DRAIN cycles, state SWAP_WAIT; rst_in mid-ISSUE -> all outputs return to reset values on the next edge.
